// File: rtl/key_scan_enc.sv
// Debounced five-button scanner driving a one-hot KEY bus with UP/DOWN auto-repeat
// and a one-cycle KEY_EVT strobe on every 00 -> code transition.
module key_scan_enc #(
  parameter int DEBOUNCE_CYC  = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int GAP_CYC       = 2,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 25
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [4:0] BTN,
  output logic [7:0] KEY,
  output logic       KEY_EVT
);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    GAP,
    DB_RELEASE
  } state_t;

  // Each threshold is compared one below its count, since the counter starts at 0
  // on the edge that enters the state.
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic is_onehot(input logic [4:0] v);
    is_onehot = (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [4:0] v);
    onehot_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (v[i]) onehot_idx = 3'(i);
    end
  endfunction

  logic [4:0]       btn_p0, btn_p1;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       cand, cand_nx;
  logic             rep_phase, rep_phase_nx;
  logic [7:0]       key_nx;
  logic             evt_nx;
  logic [4:0]       cand_hot;
  logic [7:0]       cand_code;
  logic             rep_key;
  logic [CNT_W-1:0] rep_last;

  assign cand_hot  = 5'b00001 << cand;
  assign cand_code = {cand_hot, 3'b000};
  assign rep_key   = (REPEAT_EN != 0) && (cand <= 3'd1);
  assign rep_last  = rep_phase ? RPT_PER_LAST : RPT_DLY_LAST;

  always_comb begin
    state_nx     = state;
    cnt_nx       = sat_inc(cnt);
    cand_nx      = cand;
    rep_phase_nx = rep_phase;
    key_nx       = KEY;
    evt_nx       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (is_onehot(btn_p1)) begin
          cand_nx      = onehot_idx(btn_p1);
          rep_phase_nx = 1'b0;
          state_nx     = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (btn_p1 != cand_hot) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DB_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          key_nx   = cand_code;
          evt_nx   = 1'b1;
        end
      end
      PRESSED: begin
        if (btn_p1 != cand_hot) begin
          state_nx = DB_RELEASE;
          cnt_nx   = '0;
        end else if (rep_key && (cnt == rep_last)) begin
          state_nx     = GAP;
          cnt_nx       = '0;
          key_nx       = 8'h00;
          rep_phase_nx = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (btn_p1 == cand_hot) begin
            state_nx = PRESSED;
            key_nx   = cand_code;
            evt_nx   = 1'b1;
          end else begin
            state_nx = DB_RELEASE;
          end
        end
      end
      DB_RELEASE: begin
        // A bounce back to the held key resumes it silently; anything else
        // restarts the release debounce until every button is up.
        if (btn_p1 == 5'd0) begin
          if (cnt == DB_LAST) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            key_nx   = 8'h00;
          end
        end else if ((btn_p1 == cand_hot) && (KEY != 8'h00)) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        key_nx   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      btn_p0    <= 5'd0;
      btn_p1    <= 5'd0;
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 3'd0;
      rep_phase <= 1'b0;
      KEY       <= 8'h00;
      KEY_EVT   <= 1'b0;
    end else begin
      btn_p0    <= BTN;
      btn_p1    <= btn_p0;
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      rep_phase <= rep_phase_nx;
      KEY       <= key_nx;
      KEY_EVT   <= evt_nx;
    end
  end

endmodule

// File: tb/tb_key_scan_enc.sv
// Bench for key_scan_enc: directed scenarios plus random button traffic, all
// checked every cycle against a behavioural model of the key bus.
module tb_key_scan_enc;

  localparam int D  = 4;
  localparam int G  = 2;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int MI = 0, MD = 1, MP = 2, MG = 3, MR = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [4:0] BTN = 5'd0;
  logic [7:0] KEY;
  logic       KEY_EVT;

  always #5 CLK = ~CLK;

  key_scan_enc #(
    .DEBOUNCE_CYC (D),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .GAP_CYC      (G),
    .REPEAT_EN    (1),
    .CNT_W        (8)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .BTN    (BTN),
    .KEY    (KEY),
    .KEY_EVT(KEY_EVT)
  );

  int         checks = 0;
  int         errors = 0;
  int         evt_count = 0;
  logic       prev_evt = 1'b0;

  int         m_mode = MI;
  int         age = 0;
  int         cand = 0;
  bit         phase = 1'b0;
  logic [7:0] m_key = 8'h00;
  logic       m_evt = 1'b0;
  logic [4:0] sq[$];

  function automatic logic [4:0] hot_of(input int c);
    logic [4:0] h;
    h = 5'b00001 << c;
    return h;
  endfunction

  // Model: S is the button vector seen two edges earlier; age counts edges spent
  // in the current mode and each threshold fires when age reaches its full count.
  task automatic model_edge(input logic r, input logic [4:0] b);
    logic [4:0] s, oh;
    m_evt = 1'b0;
    if (!r) begin
      sq.delete();
      sq.push_back(5'd0);
      sq.push_back(5'd0);
      m_mode = MI; age = 0; cand = 0; phase = 1'b0; m_key = 8'h00;
    end else begin
      s = sq.pop_front();
      sq.push_back(b);
      oh = hot_of(cand);
      case (m_mode)
        MI: if ($countones(s) == 1) begin
          for (int i = 0; i < 5; i++) if (s[i]) cand = i;
          phase = 1'b0; age = 0; m_mode = MD;
        end
        MD: if (s != oh) begin
          m_mode = MI; age = 0;
        end else begin
          age++;
          if (age == D) begin
            m_mode = MP; age = 0; m_key = {oh, 3'b000}; m_evt = 1'b1;
          end
        end
        MP: if (s != oh) begin
          m_mode = MR; age = 0;
        end else begin
          age++;
          if (cand <= 1 && age == (phase ? RP : RD)) begin
            m_mode = MG; age = 0; m_key = 8'h00; phase = 1'b1;
          end
        end
        MG: begin
          age++;
          if (age == G) begin
            age = 0;
            if (s == oh) begin
              m_mode = MP; m_key = {oh, 3'b000}; m_evt = 1'b1;
            end else begin
              m_mode = MR;
            end
          end
        end
        default: if (s == 5'd0) begin
          age++;
          if (age == D) begin
            m_mode = MI; age = 0; m_key = 8'h00;
          end
        end else if (s == oh && m_key != 8'h00) begin
          m_mode = MP; age = 0;
        end else begin
          age = 0;
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] b);
    RESETN = r;
    BTN    = b;
    @(posedge CLK);
    model_edge(r, b);
    #1;
    check("key_model", 32'(KEY), 32'(m_key));
    check("evt_model", 32'(KEY_EVT), 32'(m_evt));
    check("key_low_bits", 32'(KEY[2:0]), 32'd0);
    if (prev_evt) check("evt_back_to_back", 32'(KEY_EVT), 32'd0);
    prev_evt = KEY_EVT;
    if (KEY_EVT) evt_count++;
  endtask

  task automatic hold(input logic [4:0] b, input int n);
    repeat (n) step(1'b1, b);
  endtask

  initial begin
    int e0;
    int kind, len, i0;
    logic [4:0] rb;

    // Reset
    repeat (3) step(1'b0, 5'd0);
    check("reset_key", 32'(KEY), 32'h00);
    check("reset_evt", 32'(KEY_EVT), 32'd0);
    hold(5'd0, 3);

    // MENU press, latency, no repeat, release latency
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 5'b10000);
      if (n == 6) check("t1_before_accept", 32'(KEY), 32'h00);
      if (n == 7) begin
        check("t1_key", 32'(KEY), 32'h80);
        check("t1_evt", 32'(KEY_EVT), 32'd1);
      end
      if (n == 8) check("t1_evt_off", 32'(KEY_EVT), 32'd0);
    end
    e0 = evt_count;
    hold(5'b10000, 40);
    check("t1_no_repeat", 32'(evt_count - e0), 32'd0);
    check("t1_still_held", 32'(KEY), 32'h80);
    for (int n = 1; n <= 7; n++) begin
      step(1'b1, 5'd0);
      if (n == 6) check("t1_release_hold", 32'(KEY), 32'h80);
      if (n == 7) check("t1_release", 32'(KEY), 32'h00);
    end
    hold(5'd0, 3);

    // SET bounce then stable press
    e0 = evt_count;
    repeat (5) begin
      hold(5'b01000, 2);
      hold(5'd0, 2);
    end
    check("t2_bounce_quiet", 32'(KEY), 32'h00);
    for (int n = 1; n <= 7; n++) begin
      step(1'b1, 5'b01000);
      if (n == 6) check("t2_before_accept", 32'(KEY), 32'h00);
      if (n == 7) check("t2_key", 32'(KEY), 32'h40);
    end
    hold(5'b01000, 5);
    check("t2_one_evt", 32'(evt_count - e0), 32'd1);
    hold(5'd0, 10);

    // UP auto-repeat
    for (int n = 1; n <= 7; n++) step(1'b1, 5'b00010);
    check("t3_key", 32'(KEY), 32'h10);
    e0 = evt_count;
    for (int k = 1; k <= 60; k++) begin
      step(1'b1, 5'b00010);
      if (k == 19) check("t3_before_gap", 32'(KEY), 32'h10);
      if (k == 20 || k == 21) check("t3_gap", 32'(KEY), 32'h00);
      if (k == 22) begin
        check("t3_reassert", 32'(KEY), 32'h10);
        check("t3_reassert_evt", 32'(KEY_EVT), 32'd1);
      end
      if (k == 29) check("t3_period_hold", 32'(KEY), 32'h10);
      if (k == 30) check("t3_period_gap", 32'(KEY), 32'h00);
      if (k == 32) check("t3_period_evt", 32'(KEY_EVT), 32'd1);
    end
    check("t3_evt_count", 32'(evt_count - e0), 32'd4);
    hold(5'd0, 15);
    check("t3_released", 32'(KEY), 32'h00);

    // SET held, MENU added; then two buttons from idle
    hold(5'b01000, 7);
    check("t4_set", 32'(KEY), 32'h40);
    hold(5'b11000, 10);
    check("t4_second_ignored", 32'(KEY), 32'h40);
    hold(5'd0, 10);
    check("t4_released", 32'(KEY), 32'h00);
    e0 = evt_count;
    hold(5'b00101, 15);
    check("t4_two_buttons", 32'(KEY), 32'h00);
    check("t4_two_no_evt", 32'(evt_count - e0), 32'd0);
    hold(5'd0, 5);

    // CANCEL release glitch
    hold(5'b00100, 7);
    check("t5_cancel", 32'(KEY), 32'h20);
    hold(5'b00100, 5);
    for (int n = 1; n <= 14; n++) begin
      step(1'b1, (n <= 2) ? 5'd0 : 5'b00100);
      check("t5_glitch_key", 32'(KEY), 32'h20);
      check("t5_glitch_evt", 32'(KEY_EVT), 32'd0);
    end
    hold(5'd0, 10);

    // Reset while DOWN is held; re-debounced through fresh sync flops
    hold(5'b00001, 7);
    check("t6_down", 32'(KEY), 32'h08);
    hold(5'b00001, 5);
    step(1'b0, 5'b00001);
    check("t6_reset_key", 32'(KEY), 32'h00);
    check("t6_reset_evt", 32'(KEY_EVT), 32'd0);
    for (int n = 1; n <= 7; n++) begin
      step(1'b1, 5'b00001);
      if (n == 6) check("t6_before_reaccept", 32'(KEY), 32'h00);
      if (n == 7) check("t6_reaccept", 32'(KEY), 32'h08);
    end
    hold(5'd0, 10);

    // Random button traffic against the model
    repeat (60) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 35);
      i0   = $urandom_range(0, 4);
      if (kind <= 1) rb = 5'd0;
      else if (kind <= 7) rb = hot_of(i0);
      else rb = hot_of(i0) | hot_of((i0 + 1 + $urandom_range(0, 3)) % 5);
      if (kind == 9) step(1'b0, rb);
      else hold(rb, len);
    end
    hold(5'd0, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
